// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits req_count pulses of req_high cycles separated by req_low cycles.
// Optional abort support is compiled in with `define PULSE_TRAIN_GEN_ABORT_EN.
module pulse_train_gen #(
    parameter int unsigned CNT_W      = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_high,
    input  logic [CNT_W-1:0] req_low,
    input  logic [CNT_W-1:0] req_count,
    input  logic             abort,
    output logic             pulse_o,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] phase_q, phase_d;

    // Phase counter counts down to zero; a zero length is stretched to one cycle.
    function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        high_d  = high_q;
        low_d   = low_q;
        rem_d   = rem_q;
        phase_d = phase_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    high_d = req_high;
                    low_d  = req_low;
                    rem_d  = req_count;
                    if (req_count != '0) begin
                        state_d = S_HIGH;
                        phase_d = last_idx(req_high);
                    end else begin
                        state_d = S_DONE;
                        phase_d = '0;
                    end
                end
            end
            S_HIGH: begin
                if (phase_q != '0) begin
                    phase_d = phase_q - CNT_W'(1);
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                        phase_d = '0;
                    end else begin
                        state_d = S_LOW;
                        phase_d = last_idx(low_q);
                    end
                end
            end
            S_LOW: begin
                if (phase_q != '0) begin
                    phase_d = phase_q - CNT_W'(1);
                end else begin
                    state_d = S_HIGH;
                    phase_d = last_idx(high_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PULSE_TRAIN_GEN_ABORT_EN
        // Abort only cuts a running train short; it still ends through DONE.
        if (abort && ((state_q == S_HIGH) || (state_q == S_LOW))) begin
            state_d = S_DONE;
            rem_d   = '0;
            phase_d = '0;
        end
`endif
    end

`ifndef PULSE_TRAIN_GEN_ABORT_EN
    logic unused_abort;
    assign unused_abort = abort;
`endif

    // State, datapath and output registers; outputs follow the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            high_q    <= '0;
            low_q     <= '0;
            rem_q     <= '0;
            phase_q   <= '0;
            pulse_o   <= IDLE_LEVEL;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            high_q    <= high_d;
            low_q     <= low_d;
            rem_q     <= rem_d;
            phase_q   <= phase_d;
            pulse_o   <= (state_d == S_HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
            busy      <= (state_d == S_HIGH) || (state_d == S_LOW);
            done      <= (state_d == S_DONE);
            req_ready <= (state_d == S_IDLE);
        end
    end

endmodule
